// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-state fetch/decode/exec/writeback sequencer; optional single-step gating via SEQ_STEP_EN
module instr_sequencer (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] imem_addr,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [1:0] read_register1,
    output logic [1:0] read_register2,
    input  logic [7:0] read_data1,
    input  logic [7:0] read_data2,
    output logic [1:0] write_register,
    output logic [7:0] write_data,
    output logic       reg_write,
    output logic [7:0] pc,
    output logic [1:0] state,
    output logic       zero_flag,
    output logic       carry_flag
`ifdef SEQ_STEP_EN
    ,
    input  logic       step
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LI  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] ir;
    logic       br_taken;
    logic       fetch_go;
    logic       accept;
    logic [8:0] add_sum;
    logic [8:0] sub_diff;
    logic [1:0] opcode;

`ifdef SEQ_STEP_EN
    logic step_pending;

    // Pulses seen in any state collapse into one pending permission to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_pending <= 1'b0;
        end else begin
            step_pending <= step | (step_pending & ~accept);
        end
    end

    assign fetch_go = step_pending;
`else
    assign fetch_go = 1'b1;
`endif

    assign opcode         = ir[7:6];
    assign accept         = (cur_state == S_FETCH) && fetch_go && imem_ack;
    assign add_sum        = {1'b0, read_data1} + {1'b0, read_data2};
    assign sub_diff       = {1'b0, read_data1} - {1'b0, read_data2};
    assign imem_addr      = pc;
    assign read_register1 = ir[5:4];
    assign read_register2 = ir[3:2];
    assign write_register = ir[1:0];
    assign state          = cur_state;

    always_comb begin
        nxt_state = cur_state;
        imem_req  = 1'b0;
        reg_write = 1'b0;
        case (cur_state)
            S_FETCH: begin
                imem_req = fetch_go;
                if (accept) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: nxt_state = S_EXEC;
            S_EXEC:   nxt_state = S_WB;
            S_WB: begin
                // Gating with reset cancels a write caught mid-WB.
                reg_write = (opcode != OP_BEQ) && !reset;
                nxt_state = S_FETCH;
            end
            default:  nxt_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_FETCH;
            pc         <= 8'd0;
            ir         <= 8'd0;
            write_data <= 8'd0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            br_taken   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (accept) begin
                ir <= imem_data;
            end
            if (cur_state == S_EXEC) begin
                br_taken <= 1'b0;
                case (opcode)
                    OP_ADD: begin
                        write_data <= add_sum[7:0];
                        carry_flag <= add_sum[8];
                        zero_flag  <= (add_sum[7:0] == 8'd0);
                    end
                    OP_SUB: begin
                        write_data <= sub_diff[7:0];
                        carry_flag <= sub_diff[8];
                        zero_flag  <= (sub_diff[7:0] == 8'd0);
                    end
                    OP_LI: begin
                        write_data <= {4'b0000, ir[5:2]};
                    end
                    default: begin
                        br_taken <= (read_data1 == read_data2);
                    end
                endcase
            end
            // Branch offset is a signed 2-bit field relative to pc+1.
            if (cur_state == S_WB) begin
                if (br_taken) begin
                    pc <= pc + 8'd1 + {{6{ir[1]}}, ir[1:0]};
                end else begin
                    pc <= pc + 8'd1;
                end
            end
        end
    end

endmodule
